// File: rtl/uart_pkg.sv
// uart_pkg: shared channel FSM states and parity encodings for the UART transmitter.
package uart_pkg;
  typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_e;
  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;
endpackage

// File: rtl/uart_tx_chan.sv
// uart_tx_chan: one independent UART transmit channel with its own bit counter, bit index and FSM.
module uart_tx_chan
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = PAR_NONE,
  parameter int STOP_BITS    = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 tx_valid,
  input  logic [DATA_BITS-1:0] tx_data,
  output logic                 tx_ready,
  output logic                 tx_busy,
  output logic                 tx_pin
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  state_e               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [2:0]           idx_q, idx_d;
  logic [DATA_BITS-1:0] sh_q, sh_d;
  logic                 par_q, par_d, pin_q, pin_d, busy_q, busy_d, ready_q, ready_d;
  logic                 last, accept;
  assign last     = cnt_q == CW'(CLKS_PER_BIT - 1);
  assign accept   = tx_valid && ready_q;
  assign tx_ready = ready_q;
  assign tx_busy  = busy_q;
  assign tx_pin   = pin_q;
  // Acceptance only happens in IDLE or the last stop cycle, so it takes priority over bit stepping.
  always_comb begin
    state_d = state_q;
    cnt_d   = (state_q == IDLE || last) ? '0 : cnt_q + 1'b1;
    idx_d   = idx_q;
    sh_d    = sh_q;
    par_d   = par_q;
    if (accept) begin
      state_d = START;
      sh_d    = tx_data;
      par_d   = ^tx_data ^ (PARITY == PAR_ODD);
      idx_d   = '0;
    end else if (last) begin
      case (state_q)
        START: begin
          state_d = DATA;
          idx_d   = '0;
        end
        DATA: begin
          sh_d  = sh_q >> 1;
          idx_d = idx_q + 1'b1;
          if (idx_q == 3'(DATA_BITS - 1)) begin
            state_d = (PARITY != PAR_NONE) ? PAR : STOP;
            idx_d   = '0;
          end
        end
        PAR: begin
          state_d = STOP;
          idx_d   = '0;
        end
        STOP: begin
          if (idx_q == 3'(STOP_BITS - 1)) state_d = IDLE;
          else idx_d = idx_q + 1'b1;
        end
        default: state_d = IDLE;
      endcase
    end
    ready_d = state_d == IDLE ||
              (state_d == STOP && idx_d == 3'(STOP_BITS - 1) && cnt_d == CW'(CLKS_PER_BIT - 1));
    busy_d  = state_d != IDLE;
    pin_d   = state_d == START ? 1'b0 : state_d == DATA ? sh_d[0] : state_d == PAR ? par_d : 1'b1;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      sh_q    <= '0;
      par_q   <= 1'b0;
      pin_q   <= 1'b1;
      busy_q  <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      sh_q    <= sh_d;
      par_q   <= par_d;
      pin_q   <= pin_d;
      busy_q  <= busy_d;
      ready_q <= ready_d;
    end
  end
endmodule

// File: rtl/uart_tx_multi.sv
// uart_tx_multi: NUM_CH fully independent UART transmit channels sharing only the clock and reset.
module uart_tx_multi
  import uart_pkg::*;
#(
  parameter int NUM_CH       = 3,
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = PAR_NONE,
  parameter int STOP_BITS    = 1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_CH-1:0]           tx_valid,
  input  logic [NUM_CH*DATA_BITS-1:0] tx_data,
  output logic [NUM_CH-1:0]           tx_ready,
  output logic [NUM_CH-1:0]           tx_busy,
  output logic [NUM_CH-1:0]           tx_pin
);
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    uart_tx_chan #(
      .CLKS_PER_BIT(CLKS_PER_BIT),
      .DATA_BITS   (DATA_BITS),
      .PARITY      (PARITY),
      .STOP_BITS   (STOP_BITS)
    ) u_chan (
      .clk     (clk),
      .rst_n   (rst_n),
      .tx_valid(tx_valid[i]),
      .tx_data (tx_data[i*DATA_BITS +: DATA_BITS]),
      .tx_ready(tx_ready[i]),
      .tx_busy (tx_busy[i]),
      .tx_pin  (tx_pin[i])
    );
  end
endmodule

// File: tb/tb_uart_tx_multi.sv
// tb_uart_tx_multi: three differently configured transmitters checked cycle by cycle against a frame-bit model.
module tb_uart_tx_multi;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [2:0]  valid_a = '0, ready_a, busy_a, pin_a;
  logic [23:0] data_a = '0;
  logic [0:0]  valid_b = '0, ready_b, busy_b, pin_b;
  logic [7:0]  data_b = '0;
  logic [0:0]  valid_c = '0, ready_c, busy_c, pin_c;
  logic [6:0]  data_c = '0;
  int vectors = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // A: 3 channels, even parity; B: odd parity; C: 7 data bits, no parity, 2 stop bits, odd bit period.
  uart_tx_multi #(.NUM_CH(3), .CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1)) u_a (
    .clk(clk), .rst_n(rst_n), .tx_valid(valid_a), .tx_data(data_a),
    .tx_ready(ready_a), .tx_busy(busy_a), .tx_pin(pin_a));
  uart_tx_multi #(.NUM_CH(1), .CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) u_b (
    .clk(clk), .rst_n(rst_n), .tx_valid(valid_b), .tx_data(data_b),
    .tx_ready(ready_b), .tx_busy(busy_b), .tx_pin(pin_b));
  uart_tx_multi #(.NUM_CH(1), .CLKS_PER_BIT(3), .DATA_BITS(7), .PARITY(0), .STOP_BITS(2)) u_c (
    .clk(clk), .rst_n(rst_n), .tx_valid(valid_c), .tx_data(data_c),
    .tx_ready(ready_c), .tx_busy(busy_c), .tx_pin(pin_c));

  function automatic int cpb(int d);  return d == 2 ? 3 : 4; endfunction
  function automatic int dbits(int d); return d == 2 ? 7 : 8; endfunction
  function automatic int par(int d);  return d == 0 ? 1 : d == 1 ? 2 : 0; endfunction
  function automatic int stp(int d);  return d == 2 ? 2 : 1; endfunction
  function automatic int nch(int d);  return d == 0 ? 3 : 1; endfunction
  function automatic int nbits(int d);
    return 1 + dbits(d) + (par(d) != 0 ? 1 : 0) + stp(d);
  endfunction

  function automatic logic exp_bit(int d, logic [7:0] x, int b);
    logic p = 1'b0;
    if (b == 0) return 1'b0;
    if (b <= dbits(d)) return x[b-1];
    if (b == dbits(d) + 1 && par(d) != 0) begin
      for (int i = 0; i < dbits(d); i++) p ^= x[i];
      return par(d) == 2 ? ~p : p;
    end
    return 1'b1;
  endfunction

  function automatic logic get_pin(int d, int c);
    return d == 0 ? pin_a[c] : d == 1 ? pin_b[0] : pin_c[0];
  endfunction
  function automatic logic get_busy(int d, int c);
    return d == 0 ? busy_a[c] : d == 1 ? busy_b[0] : busy_c[0];
  endfunction
  function automatic logic get_ready(int d, int c);
    return d == 0 ? ready_a[c] : d == 1 ? ready_b[0] : ready_c[0];
  endfunction

  task automatic set_in(int d, int c, logic v, logic [7:0] x);
    if (d == 0) begin
      valid_a[c] = v;
      data_a[8*c +: 8] = x;
    end else if (d == 1) begin
      valid_b[0] = v;
      data_b = x;
    end else begin
      valid_c[0] = v;
      data_c = x[6:0];
    end
  endtask

  task automatic chk(string tag, logic obs, logic exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic idle_chk(int d, string tag);
    for (int c = 0; c < nch(d); c++) begin
      chk($sformatf("%s d%0d c%0d pin", tag, d, c), get_pin(d, c), 1'b1);
      chk($sformatf("%s d%0d c%0d busy", tag, d, c), get_busy(d, c), 1'b0);
      chk($sformatf("%s d%0d c%0d ready", tag, d, c), get_ready(d, c), 1'b1);
    end
  endtask

  // Called at a negedge: offer frame x on masked channels, then check every cycle of the frame.
  // Mid-frame the inputs are scrambled; in the final cycle valid is set to keep with data nx.
  task automatic send(int d, logic [2:0] m, logic [23:0] x, bit keep, logic [23:0] nx);
    int len = nbits(d) * cpb(d);
    for (int c = 0; c < nch(d); c++)
      if (m[c]) begin
        chk($sformatf("accept d%0d c%0d ready", d, c), get_ready(d, c), 1'b1);
        set_in(d, c, 1'b1, x[8*c +: 8]);
      end
    for (int k = 0; k < len; k++) begin
      @(negedge clk);
      for (int c = 0; c < nch(d); c++) begin
        if (m[c]) begin
          chk($sformatf("pin d%0d c%0d cyc%0d", d, c, k), get_pin(d, c),
              exp_bit(d, x[8*c +: 8], k / cpb(d)));
          chk($sformatf("busy d%0d c%0d cyc%0d", d, c, k), get_busy(d, c), 1'b1);
          chk($sformatf("ready d%0d c%0d cyc%0d", d, c, k), get_ready(d, c), k == len - 1);
          if (k < len - 1) set_in(d, c, 1'($urandom), 8'($urandom));
          else set_in(d, c, keep, nx[8*c +: 8]);
        end else begin
          chk($sformatf("quiet d%0d c%0d cyc%0d pin", d, c, k), get_pin(d, c), 1'b1);
          chk($sformatf("quiet d%0d c%0d cyc%0d busy", d, c, k), get_busy(d, c), 1'b0);
        end
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, observed timeout required finish");
    $fatal(1);
  end

  initial begin
    logic [2:0]  m;
    logic [23:0] x, nx;
    bit          keep;
    repeat (3) @(negedge clk);
    for (int d = 0; d < 3; d++) idle_chk(d, "reset");
    rst_n = 1'b1;
    send(0, 3'b001, 24'hA5, 1'b0, 24'h0);
    @(negedge clk); idle_chk(0, "after A5");
    send(1, 3'b001, 24'h01, 1'b0, 24'h0);
    @(negedge clk); idle_chk(1, "after odd 01");
    send(1, 3'b001, 24'h00, 1'b0, 24'h0);
    @(negedge clk); idle_chk(1, "after odd 00");
    send(0, 3'b001, 24'h55, 1'b1, 24'hAA);
    send(0, 3'b001, 24'hAA, 1'b0, 24'h0);
    @(negedge clk); idle_chk(0, "after b2b");
    send(0, 3'b111, 24'h332211, 1'b0, 24'h0);
    @(negedge clk); idle_chk(0, "after 3ch");
    send(2, 3'b001, 24'h7F, 1'b0, 24'h0);
    @(negedge clk); idle_chk(2, "after 7F");
    set_in(0, 0, 1'b1, 8'hC3);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      set_in(0, 0, 1'b0, 8'h00);
    end
    chk("pre-reset busy", get_busy(0, 0), 1'b1);
    #1 rst_n = 1'b0;
    #1 idle_chk(0, "async reset");
    @(negedge clk); idle_chk(0, "held reset");
    rst_n = 1'b1;
    send(0, 3'b001, 24'h3C, 1'b0, 24'h0);
    @(negedge clk); idle_chk(0, "after reset frame");
    for (int r = 0; r < 8; r++) begin
      m = 3'($urandom_range(1, 7));
      x = 24'($urandom);
      nx = 24'($urandom);
      keep = 1'($urandom);
      send(0, m, x, keep, nx);
      if (keep) send(0, m, nx, 1'b0, 24'h0);
      @(negedge clk); idle_chk(0, $sformatf("after random %0d", r));
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule

// File: doc/uart_tx_multi.md
UART_TX_MULTI -- requirements
Module: uart_tx_multi

Interface
REQ-001 SHALL have parameter NUM_CH, default 3: number of independent transmit channels, range 1..8.
REQ-002 SHALL have parameter CLKS_PER_BIT, default 16: clock cycles per serial bit, range 2..65535.
REQ-003 SHALL have parameter DATA_BITS, default 8: payload bits per frame, range 5..8.
REQ-004 SHALL have parameter PARITY, default 0: 0 = none, 1 = even, 2 = odd.
REQ-005 SHALL have parameter STOP_BITS, default 1: stop bits per frame, 1 or 2.
REQ-006 SHALL have port clk  input  1: the single clock; all state is on its rising edge.
REQ-007 SHALL have port rst_n  input  1: asynchronous, active-low reset.
REQ-008 SHALL have port tx_valid  input  NUM_CH: per-channel request to send.
REQ-009 SHALL have port tx_data  input  NUM_CH*DATA_BITS: channel c payload at bits [c*DATA_BITS +: DATA_BITS].
REQ-010 SHALL have port tx_ready  output  NUM_CH: per-channel "can accept".
REQ-011 SHALL have port tx_busy  output  NUM_CH: channel is mid-frame.
REQ-012 SHALL have port tx_pin  output  NUM_CH: serial line, idle high.

Function
REQ-013 SHALL run each channel fully independently, with its own bit-cycle counter, bit index and FSM; there SHALL be no shared baud tick.
REQ-014 SHALL implement the per-channel FSM states IDLE, START, DATA, PAR, STOP.
REQ-015 SHALL accept a byte on channel c when tx_valid[c] and tx_ready[c] are both high at a rising edge, capturing tx_data into a shift register.
REQ-016 SHALL drive tx_ready[c] high in IDLE, and in the final cycle of the final stop bit, to allow back-to-back frames with no idle gap; tx_ready SHALL be low otherwise.
REQ-017 SHALL drive tx_pin[c] low (start bit) in the cycle after acceptance, and hold each bit for exactly CLKS_PER_BIT cycles.
REQ-018 SHALL transmit data LSB first over DATA_BITS bit periods.
REQ-019 SHALL, when PARITY is 1, send the XOR of the payload; when PARITY is 2, send its inverse; when PARITY is 0, skip the PAR state.
REQ-020 SHALL send STOP_BITS periods of logic high.
REQ-021 SHALL have a total frame length of (1 + DATA_BITS + (PARITY != 0) + STOP_BITS) * CLKS_PER_BIT cycles.
REQ-022 SHALL transition from STOP to START on acceptance in the last stop cycle, and otherwise from STOP to IDLE.
REQ-023 SHALL assert tx_busy[c] in START, DATA, PAR and STOP, and deassert it in IDLE.
REQ-024 SHALL ignore changes to tx_data or tx_valid during a frame; the payload is latched at acceptance only.
REQ-025 SHALL register tx_pin with no combinational path from inputs; the counter SHALL be $clog2(CLKS_PER_BIT) bits wide and wrap from CLKS_PER_BIT-1 to 0 at each bit boundary.
REQ-026 SHALL process simultaneous acceptance on several channels independently, each frame starting on the next cycle.

Reset
REQ-027 SHALL, while rst_n is low, immediately force every channel to IDLE with tx_pin = 1, tx_busy = 0, tx_ready = 1, and counters and shift registers cleared.
REQ-028 SHALL abort any frame in progress when reset is asserted mid-frame; the line returns high with no partial stop bit required.
REQ-029 SHALL permit a valid frame to be accepted on the first rising edge after reset deassertion.

Structure
REQ-030 SHALL place the FSM state enum and the PARITY encoding constants (PAR_NONE, PAR_EVEN, PAR_ODD) in the shared package uart_pkg.
REQ-031 SHALL implement one natural sub-module, uart_tx_chan: a single channel FSM, counter and shift register, instantiated NUM_CH times in a generate loop.

Verification
REQ-032 The bench SHALL check: CLKS_PER_BIT=4, DATA_BITS=8, PARITY=1, ch0 sends 0xA5 -> tx_pin = 0, 1,0,1,0,0,1,0,1, 0 (parity), 1, each bit held 4 cycles, 44 cycles total, tx_ready high again on cycle 44.
REQ-033 The bench SHALL check: same configuration with PARITY=2, data 0x01 -> parity bit 0; with data 0x00 -> parity bit 1.
REQ-034 The bench SHALL check: tx_valid held high with 0x55 then 0xAA -> second start bit immediately follows the stop bit, with no extra high cycle.
REQ-035 The bench SHALL check: NUM_CH=3, all channels accepting in the same cycle with 0x11, 0x22, 0x33 -> three correct, cycle-aligned frames.
REQ-036 The bench SHALL check: rst_n pulsed low at cycle 10 of a frame -> tx_pin = 1 and tx_busy = 0 asynchronously, and a new frame is accepted on the first edge after release.
REQ-037 The bench SHALL check: DATA_BITS=7, STOP_BITS=2, PARITY=0, data 0x7F -> frame of 10 bit periods, with tx_data changed mid-frame having no effect.
